// File: rtl/iris_argmax_classifier_if.sv
// Bundles the three output-neuron results and the classifier result bus.
// The master side drives results and Readys; the slave side is the classifier.
interface iris_argmax_classifier_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         En;
    logic signed [DATA_WIDTH-1:0] Y1;
    logic signed [DATA_WIDTH-1:0] Y2;
    logic signed [DATA_WIDTH-1:0] Y3;
    logic                         Ready1;
    logic                         Ready2;
    logic                         Ready3;
    logic [1:0]                   Class;
    logic signed [DATA_WIDTH-1:0] Max_Val;
    logic                         Valid;
    logic                         Busy;

    modport master (
        output En, Y1, Y2, Y3, Ready1, Ready2, Ready3,
        input  Class, Max_Val, Valid, Busy
    );

    modport slave (
        input  En, Y1, Y2, Y3, Ready1, Ready2, Ready3,
        output Class, Max_Val, Valid, Busy
    );
endinterface

// File: rtl/iris_argmax_classifier.sv
// Collects the three Iris output-neuron results, then runs a sequential signed
// argmax (one class per cycle) and publishes the winner with a one-cycle Valid.
module iris_argmax_classifier #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    iris_argmax_classifier_if.slave   bus
);

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        INIT    = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_stateNext;

    logic [2:0]                   r_flags;
    logic signed [DATA_WIDTH-1:0] r_y1;
    logic signed [DATA_WIDTH-1:0] r_y2;
    logic signed [DATA_WIDTH-1:0] r_y3;
    logic signed [DATA_WIDTH-1:0] r_best;
    logic [1:0]                   r_bestIdx;
    logic [1:0]                   r_cnt;
    logic [1:0]                   r_class;
    logic signed [DATA_WIDTH-1:0] r_maxVal;
    logic                         r_valid;

    logic                         w_allFlags;
    logic signed [DATA_WIDTH-1:0] w_candidate;
    logic                         w_candBetter;

    assign w_allFlags   = &r_flags;
    assign w_candidate  = (r_cnt == 2'd1) ? r_y2 : r_y3;
    // Strict compare so that ties resolve to the lower class index.
    assign w_candBetter = (w_candidate > r_best);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= WAIT;
        end else if (bus.En) begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            WAIT:    if (w_allFlags) w_stateNext = INIT;
            INIT:    w_stateNext = COMPARE;
            COMPARE: if (r_cnt == 2'd2) w_stateNext = DONE;
            DONE:    w_stateNext = WAIT;
            default: w_stateNext = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flags   <= 3'b000;
            r_y1      <= '0;
            r_y2      <= '0;
            r_y3      <= '0;
            r_best    <= '0;
            r_bestIdx <= 2'd0;
            r_cnt     <= 2'd0;
            r_class   <= 2'd0;
            r_maxVal  <= '0;
        end else if (bus.En) begin
            case (r_state)
                WAIT: begin
                    // A repeated Ready simply overwrites the earlier capture.
                    if (bus.Ready1) begin
                        r_y1       <= bus.Y1;
                        r_flags[0] <= 1'b1;
                    end
                    if (bus.Ready2) begin
                        r_y2       <= bus.Y2;
                        r_flags[1] <= 1'b1;
                    end
                    if (bus.Ready3) begin
                        r_y3       <= bus.Y3;
                        r_flags[2] <= 1'b1;
                    end
                end
                INIT: begin
                    r_best    <= r_y1;
                    r_bestIdx <= 2'd0;
                    r_cnt     <= 2'd1;
                end
                COMPARE: begin
                    if (w_candBetter) begin
                        r_best    <= w_candidate;
                        r_bestIdx <= r_cnt;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                DONE: begin
                    r_class  <= r_bestIdx;
                    r_maxVal <= r_best;
                    r_flags  <= 3'b000;
                end
                default: begin
                    r_flags <= 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.En && (r_state == DONE);
        end
    end

    assign bus.Class   = r_class;
    assign bus.Max_Val = r_maxVal;
    assign bus.Valid   = r_valid;
    assign bus.Busy    = (r_state != WAIT);

endmodule

// File: tb/tb_iris_argmax_classifier.sv
// Scoreboard bench for iris_argmax_classifier: expected winners are queued as
// the last Ready is driven and compared whenever Valid is seen.
module tb_iris_argmax_classifier;

    localparam int DW = 8;

    typedef struct {
        int cls;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;
    exp_t scoreboard[$];
    exp_t popped;

    always #5 clk = ~clk;

    iris_argmax_classifier_if #(.DATA_WIDTH(DW)) bus ();

    iris_argmax_classifier #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic exp_t modelArgmax(input int a, input int b, input int c);
        exp_t r;
        r.cls = 0;
        r.val = a;
        if (b > r.val) begin r.cls = 1; r.val = b; end
        if (c > r.val) begin r.cls = 2; r.val = c; end
        return r;
    endfunction

    // Called #1 after an edge; the Readys are sampled on the following edge.
    task automatic applyStimulus(input logic [2:0] mask, input int y1, input int y2, input int y3);
        bus.Y1     = y1[DW-1:0];
        bus.Y2     = y2[DW-1:0];
        bus.Y3     = y3[DW-1:0];
        bus.Ready1 = mask[0];
        bus.Ready2 = mask[1];
        bus.Ready3 = mask[2];
        @(posedge clk);
        #1;
        bus.Ready1 = 1'b0;
        bus.Ready2 = 1'b0;
        bus.Ready3 = 1'b0;
    endtask

    task automatic measureLatency(input string tag);
        int n = 0;
        int busyCnt = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.Busy) busyCnt++;
            if (bus.Valid) n = i;
        end
        checkOutput({tag, "_latency"}, n, 5);
        checkOutput({tag, "_busy_cycles"}, busyCnt, 4);
    endtask

    task automatic runFull(input string tag, input int y1, input int y2, input int y3);
        scoreboard.push_back(modelArgmax(y1, y2, y3));
        applyStimulus(3'b111, y1, y2, y3);
        measureLatency(tag);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.Valid) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                popped = scoreboard.pop_front();
                checkOutput("class", int'(bus.Class), popped.cls);
                checkOutput("max_val", int'(bus.Max_Val), popped.val);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.En     = 1'b1;
        bus.Y1     = '0;
        bus.Y2     = '0;
        bus.Y3     = '0;
        bus.Ready1 = 1'b0;
        bus.Ready2 = 1'b0;
        bus.Ready3 = 1'b0;
        rst        = 1'b0;
        idleCycles(3);
        checkOutput("reset_class", int'(bus.Class), 0);
        checkOutput("reset_max_val", int'(bus.Max_Val), 0);
        checkOutput("reset_valid", int'(bus.Valid), 0);
        checkOutput("reset_busy", int'(bus.Busy), 0);
        rst = 1'b1;
        idleCycles(2);

        runFull("same_cycle", 3, 20, 7);

        // Staggered arrivals: no Valid may appear until the third result lands.
        applyStimulus(3'b100, 0, 0, 40);
        idleCycles(1);
        applyStimulus(3'b001, 5, 0, 40);
        idleCycles(3);
        checkOutput("stagger_not_busy", int'(bus.Busy), 0);
        scoreboard.push_back(modelArgmax(5, 12, 40));
        applyStimulus(3'b010, 5, 12, 40);
        measureLatency("stagger");

        runFull("tie_low", 9, 9, 4);
        runFull("tie_mid", 1, 15, 15);
        runFull("negative", -8, -3, -100);

        applyStimulus(3'b001, 50, 0, 0);
        applyStimulus(3'b001, 2, 0, 0);
        applyStimulus(3'b010, 2, 6, 0);
        scoreboard.push_back(modelArgmax(2, 6, 1));
        applyStimulus(3'b100, 2, 6, 1);
        measureLatency("repeat_ready");

        // Abort mid-compare, then pulse Readys with En low: nothing may be captured.
        applyStimulus(3'b111, 10, 30, 20);
        idleCycles(3);
        checkOutput("mid_compare_busy", int'(bus.Busy), 1);
        rst = 1'b0;
        idleCycles(1);
        rst = 1'b1;
        checkOutput("abort_class", int'(bus.Class), 0);
        checkOutput("abort_max_val", int'(bus.Max_Val), 0);
        checkOutput("abort_valid", int'(bus.Valid), 0);
        checkOutput("abort_busy", int'(bus.Busy), 0);
        idleCycles(8);
        bus.En = 1'b0;
        applyStimulus(3'b111, 60, 70, 80);
        idleCycles(1);
        bus.En = 1'b1;
        idleCycles(8);
        checkOutput("en_low_busy", int'(bus.Busy), 0);
        checkOutput("en_low_class", int'(bus.Class), 0);

        runFull("after_reset", 4, -2, 11);
        idleCycles(3);

        checkOutput("scoreboard_empty", scoreboard.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
